dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Responder end of the core's data-memory request interface (valid/addr/wdata/byte_enable/flash out; ready/rdata in).
- Models a word-addressed on-chip data RAM with configurable response latency and flush-stall timing.
- Sits between the core's dcache port and the system. Used as the simulation/FPGA data memory and as the reference responder for core verification.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words of storage (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- LATENCY, 2, cycles from request accept to ready_o pulse; legal range 1..15.
- FLUSH_CYCLES, 8, cycles the block stays busy servicing a flash request; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  request valid from core; held with stable addr/wdata/byte_enable until ready_o.
- addr_i  in  32  byte address (addr_t); bits [1:0] ignored.
- wdata_i  in  32  write data (data_t).
- byte_enable_i  in  4  byte_en_t; 4'b0000 = read, nonzero = write of enabled byte lanes.
- flash_i  in  1  flush request pulse.
- ready_o  out  1  one-cycle response strobe.
- rdata_o  out  32  read data, valid in the ready_o cycle.
- busy_o  out  1  high in any state other than IDLE.
- error_o  out  1  one-cycle pulse with ready_o when the request address is out of range.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, ready_o=0, rdata_o=0, busy_o=0, error_o=0, counter=0, pending-flash flag=0. RAM contents are not cleared.
- Reset mid-transaction aborts it. No ready_o is produced. A write already committed at accept remains in RAM.
- States are IDLE, WAIT, RESP, FLUSH.
- IDLE with pending flash or flash_i=1: go to FLUSH and clear the flag. This has priority over valid_i.
- IDLE with valid_i=1 and no flash: accept the request.
  - Compute index = (addr_i - BASE_ADDR) >> 2.
  - Out of range when addr_i < BASE_ADDR or index >= DEPTH_WORDS.
  - Write in range: RAM[index] byte lanes where byte_enable_i[k]=1 take wdata_i[8k+7:8k]. Other lanes are unchanged. The write commits at the accept edge.
  - Read in range: the word is latched at accept.
  - Out of range: the write is dropped; read data = 0.
  - LATENCY=1: go to RESP. Otherwise go to WAIT with counter=LATENCY-1.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP. Request inputs are ignored.
- RESP: ready_o=1 for exactly this cycle.
  - rdata_o = latched read word, or 0 for writes and out-of-range accesses.
  - error_o=1 if out of range.
  - Next state is IDLE.
- Latency: request accepted at edge T gives ready_o high in cycle T+LATENCY.
- rdata_o holds its value after RESP until the next RESP.
- Back-to-back requests: valid_i high in the cycle after RESP is a new request, accepted in IDLE. Minimum spacing between ready pulses is LATENCY+1 cycles.
- flash_i in WAIT/RESP/FLUSH: sets the pending flag, which is serviced from IDLE. Multiple pulses while pending collapse into one flush.
- FLUSH: lasts FLUSH_CYCLES cycles, then IDLE. A request valid during FLUSH waits; it is accepted in the first IDLE cycle.
- Read-after-write to the same address returns the merged written data.
- rdata_o is driven only from the latch, so there is no combinational path from valid_i to ready_o.

Test Plan:
- Reset with LATENCY=2: drive valid_i=1, addr=0x10, be=4'b1111, wdata=0xDEADBEEF at cycle 0, then a read of 0x10 -> ready_o at cycles 2 and 5; second rdata_o=0xDEADBEEF; error_o=0 both times.
- Partial write: RAM[0x20]=0x11223344, then be=4'b0101, wdata=0xAABBCCDD -> read 0x20 returns 0x11BB33DD.
- Out of range with DEPTH_WORDS=4096: read of 0x4000 -> ready_o with rdata_o=0, error_o=1. A write to 0x4000 is dropped, and a read of 0x0 is unchanged.
- flash_i pulse with valid_i in the same IDLE cycle, FLUSH_CYCLES=8, LATENCY=2 -> busy_o high; request accepted 8 cycles later; ready_o 2 cycles after that.
- rst asserted during WAIT of a write to 0x30 -> no ready_o, all outputs 0 next cycle; subsequent read of 0x30 returns the written data.
- LATENCY=1 with valid_i held high continuously for 4 reads -> ready_o every 2nd cycle; 4 pulses in 8 cycles with the correct data each.

Source files
------------

// File: rtl/dcache_responder.sv
// dcache_responder
// Responder end of the core's data-memory request interface. Models a
// word-addressed on-chip data RAM that answers each request with a one-cycle
// ready_o strobe a fixed number of cycles after accepting it. It also models
// a flush operation that keeps the block busy for a fixed number of cycles.
//
// Parameters
//   DEPTH_WORDS  : number of 32-bit words of storage (power of two)
//   BASE_ADDR    : byte address of word 0 (expected to be word aligned)
//   LATENCY      : cycles from request accept to ready_o (1..15)
//   FLUSH_CYCLES : cycles spent in FLUSH per flush request (1..255)
//
// Ports
//   clk           : clock, all logic on the rising edge
//   rst           : synchronous active-high reset
//   valid_i       : request valid, inputs held stable until ready_o
//   addr_i        : byte address, bits [1:0] ignored
//   wdata_i       : write data
//   byte_enable_i : 4'b0000 = read, otherwise write of the enabled lanes
//   flash_i       : flush request pulse
//   ready_o       : one-cycle response strobe
//   rdata_o       : read data, valid with ready_o and held until the next one
//   busy_o        : high whenever the block is not idle
//   error_o       : one-cycle pulse with ready_o for out-of-range addresses
module dcache_responder #(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned FLUSH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byte_enable_i,
  input  logic        flash_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        error_o
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [7:0]  LAT_INIT   = 8'(LATENCY - 1);
  localparam logic [7:0]  FLUSH_INIT = 8'(FLUSH_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, FLUSH} state_t;

  state_t      state;
  logic [7:0]  count;
  logic        flash_pend;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   word_off;
  logic [AW-1:0] index;
  logic          out_of_range;
  logic          is_write;
  logic          flush_go;
  logic          accept;
  logic [31:0]   acc_data;

  // Address decode works on word addresses, so the two byte-offset bits
  // drop out before the subtraction. Anything below the base, or past the
  // top of the array once rebased, is out of range.
  assign word_off     = addr_i[31:2] - BASE_ADDR[31:2];
  assign index        = word_off[AW-1:0];
  assign out_of_range = (addr_i < BASE_ADDR) || (word_off[29:AW] != '0);
  assign is_write     = |byte_enable_i;

  // A flush (fresh pulse or one remembered while busy) wins over a request
  // in the same idle cycle; the request simply waits for the next idle cycle.
  assign flush_go = (state == IDLE) && (flash_pend || flash_i);
  assign accept   = (state == IDLE) && !flush_go && valid_i;

  // The word returned to the core is captured at accept time. Writes and
  // out-of-range accesses report zero.
  assign acc_data = (is_write || out_of_range) ? '0 : mem[index];

  // Storage. The write commits on the accept edge, so a reset that arrives
  // later in the transaction cannot undo it. The RAM is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && accept && is_write && !out_of_range) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_enable_i[k]) begin
          mem[index][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Control FSM. All outputs are registered and set on the edge that enters
  // the state they describe, so ready_o/error_o line up with RESP and busy_o
  // tracks "not IDLE" without any combinational path from the request inputs.
  // A flash pulse seen while busy is remembered in flash_pend; repeated
  // pulses collapse into a single flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      flash_pend <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      ready_o    <= 1'b0;
      rdata_o    <= '0;
      busy_o     <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      error_o <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_go) begin
            state      <= FLUSH;
            count      <= FLUSH_INIT;
            flash_pend <= 1'b0;
            busy_o     <= 1'b1;
          end else if (valid_i) begin
            busy_o <= 1'b1;
            if (LATENCY == 1) begin
              state   <= RESP;
              ready_o <= 1'b1;
              rdata_o <= acc_data;
              error_o <= out_of_range;
            end else begin
              state     <= WAIT;
              count     <= LAT_INIT;
              resp_data <= acc_data;
              resp_err  <= out_of_range;
            end
          end
        end
        WAIT: begin
          if (flash_i) flash_pend <= 1'b1;
          if (count == 8'd1) begin
            state   <= RESP;
            ready_o <= 1'b1;
            rdata_o <= resp_data;
            error_o <= resp_err;
          end else begin
            count <= count - 8'd1;
          end
        end
        RESP: begin
          if (flash_i) flash_pend <= 1'b1;
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        FLUSH: begin
          if (flash_i) flash_pend <= 1'b1;
          if (count == 8'd1) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            count <= count - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder
// Drives two dcache_responder instances with the same stimulus: lane 0 with
// LATENCY=2 and lane 1 with LATENCY=1. Each lane has a transaction-level
// reference model that tracks cycle numbers ("free at", "respond at") and a
// plain memory array. The model is compared against the lane's outputs on
// every falling edge. Directed sequences add hand-computed expectations.
module tb_dcache_responder;

  localparam int DEPTH = 4096;
  localparam int FLUSH = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        flash;

  logic [1:0]  ready_v;
  logic [1:0]  busy_v;
  logic [1:0]  error_v;
  logic [31:0] rdata_v [2];

  int vectors;
  int misses;

  logic [31:0] vals [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check bumps the counters printed in the
  // summary line.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Inputs are changed just after a rising edge, so they are stable for the
  // model sampling at the falling edge and for the DUT at the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] w,
                               input logic [3:0] b, input logic f);
    valid = v;
    addr  = a;
    wdata = w;
    be    = b;
    flash = f;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One request on lane 0. valid is held until ready_o and dropped in the
  // cycle after, which leaves lane 0 idle on return.
  task automatic doRequest(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b,
                           output logic [31:0] rd, output logic er);
    bit got;
    got = 1'b0;
    rd  = '0;
    er  = 1'b0;
    applyStimulus(1'b1, a, w, b, 1'b0);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready_v[0]) begin
        got = 1'b1;
        rd  = rdata_v[0];
        er  = error_v[0];
      end
      nextCycle();
    end
    if (!got) checkOutput("request_timeout", 32'd0, 32'd1);
    applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 2 : 1;

    dcache_responder #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .LATENCY     (LAT),
      .FLUSH_CYCLES(FLUSH)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .byte_enable_i(be),
      .flash_i      (flash),
      .ready_o      (ready_v[g]),
      .rdata_o      (rdata_v[g]),
      .busy_o       (busy_v[g]),
      .error_o      (error_v[g])
    );

    logic [31:0] mem [DEPTH];

    // Reference model. "now" counts cycles. A request accepted in idle cycle
    // n responds in cycle n+LAT, and the block is idle again from n+LAT+1.
    // A flush started in cycle n keeps it busy until n+FLUSH. Each falling
    // edge first checks the current cycle, then consumes this cycle's inputs
    // to predict the next cycle.
    initial begin : model
      int          now;
      int          freeAt;
      int          respAt;
      bit          pend;
      bit          started;
      bit          respErr;
      bit          oor;
      longint      off;
      int          idx;
      logic [31:0] respData;
      logic        expReady;
      logic        expError;
      logic        expBusy;
      logic [31:0] expRdata;
      now = 0; freeAt = 0; respAt = -1; pend = 0; started = 0; respErr = 0;
      respData = '0; expReady = 0; expError = 0; expBusy = 0; expRdata = '0;
      forever begin
        @(negedge clk);
        if (started) begin
          checkOutput($sformatf("lane%0d_ready", g), 32'(ready_v[g]), 32'(expReady));
          checkOutput($sformatf("lane%0d_error", g), 32'(error_v[g]), 32'(expError));
          checkOutput($sformatf("lane%0d_busy", g),  32'(busy_v[g]),  32'(expBusy));
          checkOutput($sformatf("lane%0d_rdata", g), rdata_v[g], expRdata);
        end
        if (rst) begin
          started  = 1'b1;
          freeAt   = now + 1;
          respAt   = -1;
          pend     = 1'b0;
          respErr  = 1'b0;
          expRdata = '0;
        end else if (now >= freeAt) begin
          if (pend || flash) begin
            pend   = 1'b0;
            freeAt = now + 1 + FLUSH;
          end else if (valid) begin
            off = longint'(addr) - longint'(BASE);
            oor = (off < 0) || (off / 4 >= DEPTH);
            idx = oor ? 0 : int'(off / 4);
            respData = '0;
            if (!oor && be != 4'h0) begin
              for (int k = 0; k < 4; k++)
                if (be[k]) mem[idx][8*k +: 8] = wdata[8*k +: 8];
            end else if (!oor) begin
              respData = mem[idx];
            end
            respErr = oor;
            respAt  = now + LAT;
            freeAt  = now + LAT + 1;
          end
        end else if (flash) begin
          pend = 1'b1;
        end
        now++;
        expReady = (now == respAt);
        expError = expReady && respErr;
        if (expReady) expRdata = respData;
        expBusy = (now < freeAt);
      end
    end
  end

  // Global bound so a stuck run still terminates with a failure line.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] rd;
    logic        er;
    int          pulses;
    vectors = 0;
    misses  = 0;
    vals[0] = 32'h1111_0040;
    vals[1] = 32'h2222_0044;
    vals[2] = 32'h3333_0048;
    vals[3] = 32'h4444_004C;
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] write 0x10 then read it back, LATENCY=2");
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("t1_reset_busy", 32'(busy_v[0]), 32'd0);
        checkOutput("t1_reset_rdata", rdata_v[0], 32'd0);
      end
      checkOutput($sformatf("t1_ready_c%0d", c), 32'(ready_v[0]), 32'((c == 2) || (c == 5)));
      if (c == 2 || c == 5) checkOutput("t1_error", 32'(error_v[0]), 32'd0);
      if (c == 5) checkOutput("t1_rdata", rdata_v[0], 32'hDEAD_BEEF);
      nextCycle();
      if (c == 2) applyStimulus(1'b1, 32'h10, '0, 4'h0, 1'b0);
      if (c == 5) applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
    end

    $display("[TB] partial write merge");
    doRequest(32'h20, 32'h1122_3344, 4'hF, rd, er);
    checkOutput("t2_write_rdata", rd, 32'd0);
    doRequest(32'h20, 32'hAABB_CCDD, 4'b0101, rd, er);
    doRequest(32'h20, '0, 4'h0, rd, er);
    checkOutput("t2_merged", rd, 32'h11BB_33DD);
    checkOutput("t2_error", 32'(er), 32'd0);

    $display("[TB] out-of-range accesses");
    doRequest(32'h0, 32'hCAFE_F00D, 4'hF, rd, er);
    doRequest(32'h4000, '0, 4'h0, rd, er);
    checkOutput("t3_oor_rdata", rd, 32'd0);
    checkOutput("t3_oor_error", 32'(er), 32'd1);
    doRequest(32'h4000, 32'h1234_5678, 4'hF, rd, er);
    checkOutput("t3_oor_wr_error", 32'(er), 32'd1);
    doRequest(32'h0, '0, 4'h0, rd, er);
    checkOutput("t3_word0", rd, 32'hCAFE_F00D);
    checkOutput("t3_word0_error", 32'(er), 32'd0);

    $display("[TB] flash with valid in the same idle cycle");
    applyStimulus(1'b1, 32'h10, '0, 4'h0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_busy_c%0d", c), 32'(busy_v[0]),
                  32'(((c >= 1) && (c <= 8)) || (c >= 10)));
      checkOutput($sformatf("t4_ready_c%0d", c), 32'(ready_v[0]), 32'(c == 11));
      if (c == 11) checkOutput("t4_rdata", rdata_v[0], 32'hDEAD_BEEF);
      nextCycle();
      if (c == 0) flash = 1'b0;
      if (c == 11) applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
    end

    $display("[TB] repeated flash pulses while busy");
    applyStimulus(1'b1, 32'h20, '0, 4'h0, 1'b0);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 2) checkOutput("t4b_ready", 32'(ready_v[0]), 32'd1);
      if (c == 11) checkOutput("t4b_busy_last", 32'(busy_v[0]), 32'd1);
      if (c == 12) checkOutput("t4b_idle", 32'(busy_v[0]), 32'd0);
      nextCycle();
      if (c == 0 || c == 1) flash = 1'b1;
      if (c == 2) applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
    end

    $display("[TB] reset during WAIT of a write");
    applyStimulus(1'b1, 32'h30, 32'h5A5A_1234, 4'hF, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("t5_ready", 32'(ready_v[0]), 32'd0);
      checkOutput("t5_busy", 32'(busy_v[0]), 32'd0);
      checkOutput("t5_error", 32'(error_v[0]), 32'd0);
      checkOutput("t5_rdata", rdata_v[0], 32'd0);
      nextCycle();
    end
    doRequest(32'h30, '0, 4'h0, rd, er);
    checkOutput("t5_kept_write", rd, 32'h5A5A_1234);

    $display("[TB] LATENCY=1 back-to-back reads with valid held");
    for (int k = 0; k < 4; k++) doRequest(32'h40 + 32'(4 * k), vals[k], 4'hF, rd, er);
    repeat (3) nextCycle();
    pulses = 0;
    applyStimulus(1'b1, 32'h40, '0, 4'h0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready_v[1]) pulses++;
      checkOutput($sformatf("t6_ready_c%0d", c), 32'(ready_v[1]), 32'(c % 2));
      if (c % 2 == 1) checkOutput($sformatf("t6_rdata_%0d", c / 2), rdata_v[1], vals[c / 2]);
      nextCycle();
      if (c % 2 == 1 && c < 7) addr = 32'h40 + 32'(4 * ((c + 1) / 2));
      if (c == 7) applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
    end
    checkOutput("t6_pulse_count", 32'(pulses), 32'd4);

    repeat (6) nextCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
